lpcm_elastic_pipe: RTL

LPCM_ELASTIC_PIPE -- requirements
Module: lpcm_elastic_pipe

---
 rtl/lpcm_elastic_pipe.sv | 109 ++++++++++
 1 files changed

// File: rtl/lpcm_elastic_pipe.sv
// Elastic valid/ready register pipeline: DEPTH stages with bubble collapse,
// synchronous flush and a registered occupancy count.

module lpcm_elastic_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             rdy,
  input  logic             upValid,
  input  logic [WIDTH-1:0] upData,
  input  logic             flush,
  output logic             vNext,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_comb begin
    vNext = v;
    if (flush)    vNext = 1'b0;
    else if (rdy) vNext = upValid;
  end

  // Data moves only with a real word, so bubbles and flushes leave d intact.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      v <= vNext;
      if (rdy && upValid && !flush) d <= upData;
    end
  end
endmodule

module lpcm_elastic_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         resetb,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v, vNext, r, upValid;
  logic [DEPTH-1:0][WIDTH-1:0] d, upData;
  logic [OW-1:0]               occNext, occ;

  // A stage can take a word if it is empty or its own word moves on.
  always_comb begin
    r = '0;
    r[DEPTH-1] = !v[DEPTH-1] | out_ready;
    for (int k = DEPTH-2; k >= 0; k--) r[k] = !v[k] | r[k+1];
  end

  always_comb begin
    upValid    = '0;
    upData     = '0;
    upValid[0] = in_valid & !flush;
    upData[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      upValid[k] = v[k-1];
      upData[k]  = d[k-1];
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : gStage
      lpcm_elastic_pipe_stage #(.WIDTH(WIDTH)) uStage (
        .clk     (clk),
        .resetb  (resetb),
        .rdy     (r[k]),
        .upValid (upValid[k]),
        .upData  (upData[k]),
        .flush   (flush),
        .vNext   (vNext[k]),
        .v       (v[k]),
        .d       (d[k])
      );
    end
  endgenerate

  always_comb begin
    occNext = '0;
    for (int k = 0; k < DEPTH; k++) occNext = occNext + OW'(vNext[k]);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) occ <= '0;
    else         occ <= occNext;
  end

  assign in_ready  = r[0] & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign occupancy = occ;

  a_occ_matches: assert property (@(posedge clk) disable iff (!resetb)
    occupancy == OW'($countones(v)));
  a_full_stalls: assert property (@(posedge clk) disable iff (!resetb)
    (&v && !out_ready) |-> !in_ready);
endmodule
